// File: rtl/config_pkg.sv
// Shared numeric configuration: element format and vector shape of the rowwise unit.
package config_pkg;

  localparam int D   = 4;
  localparam int FpW = 16;

  typedef logic signed [FpW-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]  vector_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after the pointer, wrapping.
module rr_picker #(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int              j;
  logic [IdxW-1:0] j_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    j_idx    = '0;
    for (int k = 0; k < NumReq; k++) begin
      // Wrap without a modulo so non-power-of-two NumReq stays cheap.
      j = int'(ptr_i) + k;
      if (j >= NumReq) j = j - NumReq;
      j_idx = IdxW'(j);
      if (!any_o && valid_i[j_idx]) begin
        any_o           = 1'b1;
        idx_o           = j_idx;
        onehot_o[j_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rowwise_arbiter.sv
// Shares one rowwise operation unit among NumReq requesters, one transaction at a time,
// with round-robin selection and a per-requester response handshake.
module rowwise_arbiter
  import config_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  vector_t             req_a_i [NumReq],
  input  vector_t             req_b_i [NumReq],
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  output vector_t             rsp_vector_o,
  output logic [NumReq-1:0]   rsp_valid_o,
  input  logic [NumReq-1:0]   rsp_ready_i,
  output vector_t             op_a_o,
  output vector_t             op_b_o,
  output logic                op_in_valid_o,
  input  logic                op_in_ready_i,
  input  vector_t             op_vector_i,
  input  logic                op_out_valid_i,
  output logic                op_out_ready_o,
  output logic [IdxW-1:0]     grant_id_o,
  output logic                busy_o,
  output logic [31:0]         txn_count_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, RESPOND} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, grant_q;
  vector_t         a_q, b_q, result_q;
  logic [31:0]     txn_q;

  logic [NumReq-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;

  rr_picker #(.NumReq(NumReq)) u_picker (
    .valid_i  (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    if (int'(grant_q) == NumReq - 1) rr_ptr_d = '0;
    else                             rr_ptr_d = grant_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      txn_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            a_q     <= req_a_i[pick_idx];
            b_q     <= req_b_i[pick_idx];
            state_q <= ISSUE;
          end
        end
        // Operands stay frozen through WAIT_RESULT: the unit reads them element by element.
        ISSUE: begin
          if (op_in_ready_i) state_q <= WAIT_RESULT;
        end
        WAIT_RESULT: begin
          if (op_out_valid_i) begin
            result_q <= op_vector_i;
            state_q  <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready_i[grant_q]) begin
            rr_ptr_q <= rr_ptr_d;
            if (txn_q != 32'hFFFF_FFFF) txn_q <= txn_q + 32'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the IDLE winner sees ready; everything else is refused while a transaction is open.
  assign req_ready_o    = (state_q == IDLE) ? pick_onehot : '0;
  assign op_in_valid_o  = (state_q == ISSUE);
  assign op_out_ready_o = (state_q == WAIT_RESULT);
  assign op_a_o         = a_q;
  assign op_b_o         = b_q;
  assign rsp_vector_o   = result_q;
  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign txn_count_o    = txn_q;

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESPOND) rsp_valid_o[grant_q] = 1'b1;
  end

endmodule
